// File: rtl/prog_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Round-robin on contention, combinational grant, registered one-cycle response.
module prog_mem_arbiter #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_D} src_e;

  src_e r_src;
  logic r_err;
  logic r_wr;
  logic r_pri;

  logic w_if_bad, w_d_bad;
  logic w_if_win, w_d_win;
  logic w_contend;

  // MEM_WORDS is a power of two, so out-of-range means any bit above the word index is set
  assign w_if_bad = (if_addr[1:0] != 2'b00) | (|if_addr[31:AW+2]);
  assign w_d_bad  = (d_addr[1:0]  != 2'b00) | (|d_addr[31:AW+2]);

  assign w_contend = if_req & d_req;
  assign w_if_win  = if_req & (~d_req | r_pri);
  assign w_d_win   = d_req  & (~if_req | ~r_pri);

  assign if_gnt = ~rst & w_if_win;
  assign d_gnt  = ~rst & w_d_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en   = ~w_d_bad;
      mem_addr = d_addr[AW+1:2];
      if (d_we) begin
        mem_wdata = d_wdata;
        if (!w_d_bad) mem_we = d_be;
      end
    end else if (if_gnt) begin
      mem_en   = ~w_if_bad;
      mem_addr = if_addr[AW+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= SRC_NONE;
      r_err <= 1'b0;
      r_wr  <= 1'b0;
      r_pri <= 1'b0;
    end else begin
      if (d_gnt) begin
        r_src <= SRC_D;
        r_err <= w_d_bad;
        r_wr  <= d_we;
      end else if (if_gnt) begin
        r_src <= SRC_IF;
        r_err <= w_if_bad;
        r_wr  <= 1'b0;
      end else begin
        r_src <= SRC_NONE;
        r_err <= 1'b0;
        r_wr  <= 1'b0;
      end
      // loser of a contended cycle is favoured next time
      if (w_contend) r_pri <= w_d_win;
    end
  end

  assign if_rvalid = (r_src == SRC_IF);
  assign d_rvalid  = (r_src == SRC_D);
  assign if_err    = if_rvalid & r_err;
  assign d_err     = d_rvalid & r_err;
  assign if_rdata  = (if_rvalid & ~r_err) ? mem_rdata : 32'h0;
  assign d_rdata   = (d_rvalid & ~r_err & ~r_wr) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: behavioural RAM, shadow memory and a response scoreboard.
module tb_prog_mem_arbiter;
  localparam int MEM_WORDS = 256;
  localparam int AW = $clog2(MEM_WORDS);
  localparam bit P_IF = 1'b0;
  localparam bit P_D  = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [31:0]   if_addr, if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]    d_be;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  prog_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          port;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          ram_init;
  logic [31:0] ram     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  function automatic logic [31:0] init_val(int i);
    case (i)
      5:       return 32'h00110113;
      8:       return 32'h11223344;
      default: return 32'hC0DE0000 + i;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_init) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  function automatic void push_exp(bit port, bit err, logic [31:0] data);
    exp_t e;
    e.cyc = cyc + 1; e.port = port; e.err = err; e.data = data;
    q.push_back(e);
  endfunction

  // scoreboard: each grant's response must appear exactly one cycle later on its own port
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit ev, eif, ed;
      logic [31:0] erd_if, erd_d;
      e.cyc = 0; e.port = 1'b0; e.err = 1'b0; e.data = 32'h0;
      ev = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        ev = 1'b1;
      end
      eif = ev && e.port == P_IF;
      ed  = ev && e.port == P_D;
      erd_if = eif ? e.data : 32'h0;
      erd_d  = ed  ? e.data : 32'h0;
      checks++;
      if (if_rvalid !== eif || d_rvalid !== ed) begin
        errors++;
        $display("FAIL rvalid cyc=%0d got if=%b d=%b expected if=%b d=%b", cyc, if_rvalid, d_rvalid, eif, ed);
      end
      checks++;
      if (if_err !== (eif & e.err) || d_err !== (ed & e.err)) begin
        errors++;
        $display("FAIL err cyc=%0d got if=%b d=%b expected if=%b d=%b", cyc, if_err, d_err, eif & e.err, ed & e.err);
      end
      checks++;
      if (if_rdata !== erd_if || d_rdata !== erd_d) begin
        errors++;
        $display("FAIL rdata cyc=%0d got if=%h d=%h expected if=%h d=%h", cyc, if_rdata, d_rdata, erd_if, erd_d);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h14; d_addr = 32'h20;
    d_we = 1'b1; d_be = 4'hF; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt got if=%b d=%b expected 0 0", if_gnt, d_gnt);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 4'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got en=%b we=%h addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 32'h14;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== AW'(5) || mem_we !== 4'h0) begin
      errors++;
      $display("FAIL fetch_req got gnt=%b/%b en=%b addr=%h we=%h expected 1/0 1 05 0", if_gnt, d_gnt, mem_en, mem_addr, mem_we);
    end
    push_exp(P_IF, 1'b0, ref_mem[5]);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== AW'(8) || mem_wdata !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL write_req got gnt=%b en=%b we=%h addr=%h wdata=%h", d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[8][15:0] = 16'hCCDD;
    push_exp(P_D, 1'b0, 32'h0);
    @(posedge clk); #1;
    d_we = 1'b1; d_be = 4'b0000; d_addr = 32'h24; d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_we !== 4'h0) begin
      errors++; $display("FAIL write_be0 got gnt=%b we=%h expected 1 0", d_gnt, mem_we);
    end
    push_exp(P_D, 1'b0, 32'h0);
    @(posedge clk); #1;
    d_we = 1'b0; d_addr = 32'h20;
    @(negedge clk);
    push_exp(P_D, 1'b0, ref_mem[8]);
    @(posedge clk); #1;
    d_addr = 32'h24;
    @(negedge clk);
    push_exp(P_D, 1'b0, ref_mem[9]);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic test_errors();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h22;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL err_misalign_rd got gnt=%b en=%b expected 1 0", d_gnt, mem_en);
    end
    push_exp(P_D, 1'b1, 32'h0);
    @(posedge clk); #1;
    d_we = 1'b1; d_be = 4'hF; d_wdata = 32'h55555555;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'h0) begin
      errors++; $display("FAIL err_misalign_wr got gnt=%b en=%b we=%h expected 1 0 0", d_gnt, mem_en, mem_we);
    end
    push_exp(P_D, 1'b1, 32'h0);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'(4 * MEM_WORDS);
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL err_range_if got gnt=%b en=%b expected 1 0", if_gnt, mem_en);
    end
    push_exp(P_IF, 1'b1, 32'h0);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h20;
    @(negedge clk);
    push_exp(P_D, 1'b0, ref_mem[8]);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic test_contention();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (d_gnt !== (k % 2 == 0) || if_gnt !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL contention k=%0d got d=%b if=%b expected d=%b if=%b", k, d_gnt, if_gnt, k % 2 == 0, k % 2 == 1);
      end
      if (k % 2 == 0) push_exp(P_D, 1'b0, ref_mem[2]);
      else            push_exp(P_IF, 1'b0, ref_mem[0]);
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset_midop();
    if_req = 1'b1; if_addr = 32'h14;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL midrst_gnt got %b expected 1", if_gnt);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL midrst_hold k=%0d got gnt=%b en=%b expected 0 0", k, if_gnt, mem_en);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      errors++; $display("FAIL midrst_first got d=%b if=%b expected 1 0", d_gnt, if_gnt);
    end
    push_exp(P_D, 1'b0, ref_mem[2]);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      if_req = 1'b1; if_addr = 32'(4 * k);
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || mem_addr !== AW'(k)) begin
        errors++; $display("FAIL stream k=%0d got gnt=%b addr=%h expected 1 %h", k, if_gnt, mem_addr, k);
      end
      push_exp(P_IF, 1'b0, ref_mem[k]);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
    @(posedge clk); #1;
    ram_init = 1'b0; mon_en = 1'b1;
    test_reset();
    test_fetch_read();
    test_write_read();
    test_errors();
    test_contention();
    test_reset_midop();
    test_stream();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain got %0d pending responses expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Two-port arbiter that shares one single-port, word-wide synchronous program/data RAM between the core's instruction-fetch port and its load/store port. It sits between the RISC-V core and the memory array. It grants at most one request per cycle with round-robin fairness under contention, and drives the RAM enable and byte-write strobes. It returns read data or write acknowledges to the winning requester with fixed one-cycle latency, and flags misaligned or out-of-range accesses without touching the RAM.

## Interface
- MEM_WORDS, 256: RAM depth in 32-bit words; power of two, ≥ 2.
- AW, $clog2(MEM_WORDS): RAM word-address width (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  fetch response valid (registered).
- if_rdata  out  32  fetch read data.
- if_err  out  1  fetch response is an error (qualified by if_rvalid).
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  byte enables for writes.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  data response valid (registered).
- d_rdata  out  32  data read data.
- d_err  out  1  data response is an error.
- mem_en  out  1  RAM access enable.
- mem_we  out  4  RAM byte write strobes.
- mem_addr  out  AW  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en.

## Operation

**Acceptance and arbitration**
- A request is accepted in cycle N when req & gnt.
- Only one requester sees req & gnt in any cycle.
- Priority pointer `pri` (1 bit) selects the winner when both if_req and d_req are high:
  - pri = 0 → data wins.
  - pri = 1 → fetch wins.
- Single requester: it is granted regardless of pri.
- Each contended grant sets pri to favour the loser on the next cycle. Uncontended grants leave pri unchanged.
- While rst = 1: if_gnt = d_gnt = 0 and mem_en = 0.

**Address checking** (per accepted request)
- Error if addr[1:0] ≠ 0, or addr[31:2] ≥ MEM_WORDS.
- Valid request: mem_en = 1, mem_addr = addr[AW+1:2].
- Erroring request: it is still granted, but mem_en = 0 and mem_we = 0.
- Fetch has no write path: mem_we = 0 for fetch grants.
- Data write: mem_we = d_be when d_we = 1; mem_wdata = d_wdata.
- Data write with d_be = 0 is legal: it performs no byte update and returns a normal ack.

**Response state** (registered)
- `resp_src` ∈ {NONE, IF, D}, plus `resp_err` and `resp_wr`.
- Cycle N+1:
  - rvalid for the source granted in N is 1, the other is 0.
  - err = resp_err.
- Response data in N+1:
  - Valid read: rdata = mem_rdata, passed through combinationally.
  - Write, or any error: rdata = 0.
- The non-responding port's rdata = 0.

**Boundaries**
- Back-to-back grants every cycle are allowed; there are no bubbles and no outstanding limit beyond the 1-cycle pipe.
- Requests are not held by the arbiter. A requester that is not granted must keep req and its address/data stable until granted.

## Timing
- Reset values, in the cycle after a rst edge:
  - if_rvalid = d_rvalid = 0; if_err = d_err = 0; if_rdata = d_rdata = 0.
  - pri = 0; resp_src = NONE.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0 (forced while rst is high).
- Grant is combinational, same cycle as req. Response latency is exactly 1 cycle after grant.
- Reset mid-operation: a request granted in cycle N with rst = 1 at the N+1 edge produces no response, and rvalid stays 0.
- Simultaneous requests: exactly one grant. The loser is granted at the earliest one cycle later if it keeps requesting.
- Sustained contention: grants alternate D, IF, D, IF… starting with D after reset.

## Test plan
- Fetch-only read: preload mem[5] = 32'h00110113; if_req, if_addr = 0x14 → if_gnt in cycle N; if_rvalid = 1 with if_rdata = 32'h00110113 and if_err = 0 in N+1; d_rvalid = 0 throughout.
- Data write then read: d_we = 1, d_be = 4'b0011, d_addr = 0x20, d_wdata = 32'hAABBCCDD over a word holding 0x11223344 → ack with d_rdata = 0 in N+1; read of 0x20 → d_rdata = 32'h1122CCDD.
- Contention after reset: both request continuously for 6 cycles → grant sequence D, IF, D, IF, D, IF; each response arrives one cycle after its grant on the correct port.
- Errors: d_addr = 0x22 → d_err = 1, d_rdata = 0, mem_en never asserted; if_addr = 4·MEM_WORDS → if_err = 1; no RAM contents change.
- Reset mid-operation: grant a fetch in cycle N with rst = 1 across the N+1 edge → if_rvalid = 0 in N+1 and N+2; if_gnt = 0 while rst is high; after release the first contended grant goes to D.
- Streaming fetch: if_req held for 10 cycles with the address incrementing by 4 from 0 → 10 consecutive grants, and rdata sequence matches mem[0..9], each one cycle after its grant.
